palt_nios_sysid_checker: RTL and testbench
==========================================

PALT_NIOS_SYSID_CHECKER -- requirements
Module: palt_nios_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd8, system ID value the software image was built against.
REQ-002 Parameter EXPECTED_TS, default 32'd1649502956, build timestamp the software image was built against.
REQ-003 Parameter READ_LATENCY, default 1, range 0..3: cycles from read strobe to valid readdata.
REQ-004 Parameter MAX_RETRY, default 2, range 0..7: extra read passes allowed after a mismatch.
REQ-005 clock  input  1  sole clock; all state SHALL be on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that requests an identity check.
REQ-008 sysid_address  output  1  0 = ID word, 1 = timestamp word.
REQ-009 sysid_read  output  1  read strobe to the sysid control slave.
REQ-010 sysid_readdata  input  32  readdata from the sysid control slave.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse when the final result is valid.
REQ-013 match  output  1  both words equal expected; valid from done until the next accepted start.
REQ-014 id_value / ts_value  output  32 each  last sampled ID / timestamp words.
REQ-015 retries_used  output  3  number of retry passes consumed by the last check.

Function
REQ-016 FSM states SHALL be IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP.
REQ-017 IDLE: start=1 SHALL move to RD_ID; clear match, retries_used, id_value, ts_value.
REQ-018 start while busy SHALL be ignored.
REQ-019 RD_ID / RD_TS: sysid_read=1 for exactly one cycle, with sysid_address=0 / 1 respectively.
REQ-020 sysid_read and sysid_address SHALL be 0 in every other state.
REQ-021 READ_LATENCY=0: readdata SHALL be sampled in the RD_x cycle, and WAIT_x SHALL be skipped.
REQ-022 READ_LATENCY=L>0: WAIT_x SHALL last L cycles (down-counter), and readdata SHALL be sampled in its last cycle.
REQ-023 After the ID sample, go to RD_TS; after the timestamp sample, go to CMP.
REQ-024 CMP, both equal: match=1, go to IDLE, done=1 in the next cycle.
REQ-025 CMP, mismatch with retries_used<MAX_RETRY: increment retries_used, go to RD_ID, no done.
REQ-026 CMP, mismatch with retries_used==MAX_RETRY: match=0, go to IDLE, done=1.
REQ-027 Latency: for a first-pass match, done SHALL assert 2*(READ_LATENCY+1)+2 cycles after the start cycle.
REQ-028 Each retry pass SHALL add 2*(READ_LATENCY+1)+1 cycles to that latency.
REQ-029 busy SHALL deassert in the same cycle done asserts.
REQ-030 start coincident with done SHALL be accepted, and done SHALL still pulse.
REQ-031 Comparison SHALL be full 32-bit unsigned equality; no masking.

Reset
REQ-032 reset_n low SHALL force IDLE asynchronously, including mid-operation.
REQ-033 Under reset: busy, done, match, sysid_read, sysid_address = 0; id_value, ts_value = 0; retries_used = 0; latency counter = 0.
REQ-034 First start after reset release SHALL behave as in REQ-017.

Structure
REQ-035 Shared package palt_nios_pkg SHALL hold the FSM state encoding and the default EXPECTED_ID / EXPECTED_TS constants.
REQ-036 One sub-module, palt_nios_lat_cnt (loadable down-counter with zero flag), SHALL implement the WAIT_x delay.

Verification
REQ-037 L=1, slave returns 8 / 1649502956, start at cycle 0 -> reads at cycles 1, 3 (address 0, 1); done=1, match=1 at cycle 6; retries_used=0.
REQ-038 L=0, correct slave -> done at cycle 4, match=1, no WAIT cycles.
REQ-039 MAX_RETRY=2, ID word returns 9 on every pass -> 3 passes, done=1, match=0, retries_used=2, id_value=9.
REQ-040 First-pass timestamp 0, second pass correct -> match=1, retries_used=1, done at cycle 6+5=11 (L=1).
REQ-041 reset_n low at cycle 3 of a check -> all outputs 0 immediately; a new start after release completes normally.
REQ-042 start pulses at cycles 2 and 4 during a check -> ignored; start in the done cycle -> second check runs and reads at done+1.

Source files
------------

// File: rtl/palt_nios_pkg.sv
// rtl/palt_nios_pkg.sv - shared state encoding and default identity constants for the sysid checker
package palt_nios_pkg;

    // Check sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_CMP     = 3'd5
    } state_t;

    // Identity the software image was built against
    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd8;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1649502956;

endpackage

// File: rtl/palt_nios_lat_cnt.sv
// rtl/palt_nios_lat_cnt.sv - loadable down-counter with zero flag for read-latency waits
//
// Ports:
//   clock      - rising-edge clock
//   reset_n    - asynchronous active-low reset, clears the count
//   load       - load load_value (has priority over dec)
//   load_value - value to load
//   dec        - decrement by one, saturating at zero
//   zero       - count is zero
module palt_nios_lat_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/palt_nios_sysid_checker.sv
// rtl/palt_nios_sysid_checker.sv - reads sysid ID/timestamp words and compares them to build-time values
//
// Ports:
//   clock, reset_n   - clock and asynchronous active-low reset
//   start            - one-cycle request for an identity check (ignored while busy)
//   sysid_address    - 0 = ID word, 1 = timestamp word
//   sysid_read       - one-cycle read strobe to the sysid slave
//   sysid_readdata   - slave readdata, valid READ_LATENCY cycles after the strobe
//   busy             - check in progress
//   done             - one-cycle pulse when match/retries_used are final
//   match            - both words equal the expected values
//   id_value         - last sampled ID word
//   ts_value         - last sampled timestamp word
//   retries_used     - retry passes consumed by the last check
module palt_nios_sysid_checker
    import palt_nios_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS  = DEFAULT_EXPECTED_TS,
    parameter int          READ_LATENCY = 1,
    parameter int          MAX_RETRY    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  retries_used
);

    // The wait state is entered after the strobe cycle, so it counts L-1 down to zero.
    localparam logic [1:0] LAT_LOAD  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t state_q, state_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic accept;
    logic sample_id;
    logic sample_ts;
    logic retry;
    logic finish;
    logic words_equal;

    assign words_equal = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);

    palt_nios_lat_cnt #(
        .WIDTH (2)
    ) u_lat_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (LAT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sysid_read    = 1'b0;
        sysid_address = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        accept        = 1'b0;
        sample_id     = 1'b0;
        sample_ts     = 1'b0;
        retry         = 1'b0;
        finish        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                sysid_read = 1'b1;
                if (READ_LATENCY == 0) begin
                    sample_id = 1'b1;
                    state_d   = ST_RD_TS;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT_ID;
                end
            end
            ST_WAIT_ID: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    sample_id = 1'b1;
                    state_d   = ST_RD_TS;
                end
            end
            ST_RD_TS: begin
                sysid_read    = 1'b1;
                sysid_address = 1'b1;
                if (READ_LATENCY == 0) begin
                    sample_ts = 1'b1;
                    state_d   = ST_CMP;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT_TS;
                end
            end
            ST_WAIT_TS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    sample_ts = 1'b1;
                    state_d   = ST_CMP;
                end
            end
            ST_CMP: begin
                if (!words_equal && (retries_used < RETRY_MAX)) begin
                    retry   = 1'b1;
                    state_d = ST_RD_ID;
                end else begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done         <= 1'b0;
            match        <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
            retries_used <= '0;
        end else begin
            done <= finish;
            if (accept) begin
                match        <= 1'b0;
                id_value     <= '0;
                ts_value     <= '0;
                retries_used <= '0;
            end
            if (sample_id) begin
                id_value <= sysid_readdata;
            end
            if (sample_ts) begin
                ts_value <= sysid_readdata;
            end
            if (retry) begin
                retries_used <= retries_used + 3'd1;
            end
            if (finish) begin
                match <= words_equal;
            end
        end
    end

    // done is registered, so IDLE is already reached in the done cycle and busy drops with it.
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_palt_nios_sysid_checker.sv
// tb/tb_palt_nios_sysid_checker.sv - directed self-checking bench for palt_nios_sysid_checker
module tb_palt_nios_sysid_checker;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        sel     = 1'b0;

    logic [31:0] id_word = 32'd8;
    logic [31:0] ts_word = 32'd1649502956;
    int          ts_reads    = 0;
    int          ts_bad_upto = 0;

    // instance A: READ_LATENCY=1, MAX_RETRY=2
    logic        a_start, a_addr, a_read, a_busy, a_done, a_match;
    logic [31:0] a_rdata = '0;
    logic [31:0] a_id, a_ts;
    logic [2:0]  a_retries;

    // instance B: READ_LATENCY=0
    logic        b_start, b_addr, b_read, b_busy, b_done, b_match;
    logic [31:0] b_rdata;
    logic [31:0] b_id, b_ts;
    logic [2:0]  b_retries;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    palt_nios_sysid_checker #(
        .READ_LATENCY (1),
        .MAX_RETRY    (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (a_start),
        .sysid_address  (a_addr),
        .sysid_read     (a_read),
        .sysid_readdata (a_rdata),
        .busy           (a_busy),
        .done           (a_done),
        .match          (a_match),
        .id_value       (a_id),
        .ts_value       (a_ts),
        .retries_used   (a_retries)
    );

    palt_nios_sysid_checker #(
        .READ_LATENCY (0),
        .MAX_RETRY    (2)
    ) dut0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (b_start),
        .sysid_address  (b_addr),
        .sysid_read     (b_read),
        .sysid_readdata (b_rdata),
        .busy           (b_busy),
        .done           (b_done),
        .match          (b_match),
        .id_value       (b_id),
        .ts_value       (b_ts),
        .retries_used   (b_retries)
    );

    always #5 clock = ~clock;

    // one-cycle-latency slave; timestamp reads below ts_bad_upto return 0
    always @(posedge clock) begin
        if (a_read) begin
            if (a_addr) begin
                a_rdata  <= (ts_reads < ts_bad_upto) ? 32'd0 : ts_word;
                ts_reads <= ts_reads + 1;
            end else begin
                a_rdata <= id_word;
            end
        end
    end

    // zero-latency slave
    assign b_rdata = b_addr ? ts_word : id_word;

    logic        o_read, o_addr, o_busy, o_done, o_match;
    logic [31:0] o_id, o_ts;
    logic [2:0]  o_retries;
    assign o_read    = sel ? b_read    : a_read;
    assign o_addr    = sel ? b_addr    : a_addr;
    assign o_busy    = sel ? b_busy    : a_busy;
    assign o_done    = sel ? b_done    : a_done;
    assign o_match   = sel ? b_match   : a_match;
    assign o_id      = sel ? b_id      : a_id;
    assign o_ts      = sel ? b_ts      : a_ts;
    assign o_retries = sel ? b_retries : a_retries;

    int ncheck = 0;
    int nbad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncheck++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int   done_at;
    int   nrd;
    int   rd_n [8];
    int   rd_a [8];
    logic match1, busy1, busy_done;

    // Raises start at the current negedge (cycle 0) and observes cycles 1.. until done.
    task automatic run(input bit use_b, input bit extra_starts);
        int n;
        sel       = use_b;
        done_at   = -1;
        nrd       = 0;
        match1    = 1'b1;
        busy1     = 1'b0;
        busy_done = 1'b1;
        start     = 1'b1;
        n         = 0;
        while (n < 80 && done_at < 0) begin
            @(negedge clock);
            n++;
            start = extra_starts && (n == 2 || n == 4);
            if (o_read) begin
                if (nrd < 8) begin
                    rd_n[nrd] = n;
                    rd_a[nrd] = int'(o_addr);
                end
                nrd++;
            end
            if (n == 1) begin
                match1 = o_match;
                busy1  = o_busy;
            end
            if (o_done) begin
                done_at   = n;
                busy_done = o_busy;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_busy",    32'(a_busy),    32'd0);
        chk("rst_done",    32'(a_done),    32'd0);
        chk("rst_match",   32'(a_match),   32'd0);
        chk("rst_read",    32'(a_read),    32'd0);
        chk("rst_id",      a_id,           32'd0);
        chk("rst_retries", 32'(a_retries), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // first-pass match, L=1
        run(1'b0, 1'b0);
        chk("t1_done_at", 32'(done_at), 32'd6);
        chk("t1_nrd",     32'(nrd),     32'd2);
        chk("t1_rd0_cyc", 32'(rd_n[0]), 32'd1);
        chk("t1_rd0_adr", 32'(rd_a[0]), 32'd0);
        chk("t1_rd1_cyc", 32'(rd_n[1]), 32'd3);
        chk("t1_rd1_adr", 32'(rd_a[1]), 32'd1);
        chk("t1_match",   32'(o_match), 32'd1);
        chk("t1_retries", 32'(o_retries), 32'd0);
        chk("t1_id",      o_id,         32'd8);
        chk("t1_ts",      o_ts,         32'd1649502956);
        chk("t1_busy1",   32'(busy1),   32'd1);
        chk("t1_busy_dn", 32'(busy_done), 32'd0);

        // L=0, no wait cycles
        run(1'b1, 1'b0);
        chk("t2_done_at", 32'(done_at), 32'd4);
        chk("t2_nrd",     32'(nrd),     32'd2);
        chk("t2_rd0_cyc", 32'(rd_n[0]), 32'd1);
        chk("t2_rd1_cyc", 32'(rd_n[1]), 32'd2);
        chk("t2_match",   32'(o_match), 32'd1);

        // ID always wrong: three passes then give up
        id_word = 32'd9;
        run(1'b0, 1'b0);
        chk("t3_done_at", 32'(done_at), 32'd16);
        chk("t3_nrd",     32'(nrd),     32'd6);
        chk("t3_match",   32'(o_match), 32'd0);
        chk("t3_retries", 32'(o_retries), 32'd2);
        chk("t3_id",      o_id,         32'd9);
        id_word = 32'd8;

        // first timestamp read returns 0, second pass succeeds
        ts_bad_upto = ts_reads + 1;
        run(1'b0, 1'b0);
        chk("t4_done_at", 32'(done_at), 32'd11);
        chk("t4_match",   32'(o_match), 32'd1);
        chk("t4_retries", 32'(o_retries), 32'd1);
        chk("t4_ts",      o_ts,         32'd1649502956);

        // asynchronous reset in cycle 3 of a check
        sel   = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("t5_busy",    32'(a_busy),    32'd0);
        chk("t5_read",    32'(a_read),    32'd0);
        chk("t5_addr",    32'(a_addr),    32'd0);
        chk("t5_id",      a_id,           32'd0);
        chk("t5_done",    32'(a_done),    32'd0);
        chk("t5_match",   32'(a_match),   32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run(1'b0, 1'b0);
        chk("t5_post_done", 32'(done_at), 32'd6);
        chk("t5_post_match", 32'(o_match), 32'd1);

        // starts while busy are ignored; start in the done cycle is accepted
        run(1'b0, 1'b1);
        chk("t6_done_at", 32'(done_at), 32'd6);
        chk("t6_nrd",     32'(nrd),     32'd2);
        run(1'b0, 1'b0);
        chk("t6b_done_at", 32'(done_at), 32'd6);
        chk("t6b_rd0_cyc", 32'(rd_n[0]), 32'd1);
        chk("t6b_match1",  32'(match1),  32'd0);
        chk("t6b_match",   32'(o_match), 32'd1);

        $display("test done: total=%0d bad=%0d", ncheck, nbad);
        $finish;
    end

endmodule
